// File: rtl/branch_unit_if.sv
`default_nettype none
// branch_unit_if -- issue, writeback, redirect and statistics signals of the branch unit.
// Revision: 1.0
interface branch_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [63:0] in_op1;
  logic [63:0] in_op2;
  logic [63:0] in_imm;
  logic [2:0]  in_funct3;
  logic        in_is_jal;
  logic        in_is_jalr;
  logic        in_pred_taken;
  logic [63:0] in_pred_target;
  logic        in_epoch;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        out_taken;
  logic [63:0] out_target;
  logic [63:0] out_link;
  logic        out_illegal;
  logic        out_misalign;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [31:0] mispredict_cnt;

  modport master (
    output in_valid, in_pc, in_op1, in_op2, in_imm, in_funct3, in_is_jal, in_is_jalr,
           in_pred_taken, in_pred_target, in_epoch, flush, out_ready,
    input  in_ready, out_valid, out_taken, out_target, out_link, out_illegal, out_misalign,
           redirect_valid, redirect_pc, mispredict_cnt
  );

  modport slave (
    input  in_valid, in_pc, in_op1, in_op2, in_imm, in_funct3, in_is_jal, in_is_jalr,
           in_pred_taken, in_pred_target, in_epoch, flush, out_ready,
    output in_ready, out_valid, out_taken, out_target, out_link, out_illegal, out_misalign,
           redirect_valid, redirect_pc, mispredict_cnt
  );
endinterface
`default_nettype wire

// File: rtl/branch_unit.sv
`default_nettype none
// branch_unit -- resolves branches/jumps, registers the result and redirects on mispredict.
// Revision: 1.0
module branch_unit (
  input  logic         clock,
  input  logic         reset_n,
  branch_unit_if.slave bus
);

  logic [1:0]  run_sync;
  logic        run;
  logic        ready;
  logic        epoch;
  logic [31:0] cnt;
  logic        out_valid;
  logic        out_taken;
  logic        out_illegal;
  logic        out_misalign;
  logic        redirect_valid;
  logic [63:0] out_target;
  logic [63:0] out_link;

  logic        cond;
  logic        illegal;
  logic        taken;
  logic        misalign;
  logic        mispredict;
  logic        capture;
  logic        do_redirect;
  logic [63:0] jump_target;
  logic [63:0] link;
  logic [63:0] result_target;

  // Acceptance is held off until the released reset has been seen on two edges.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) run_sync <= 2'b00;
    else          run_sync <= {run_sync[0], 1'b1};
  end

  assign run   = run_sync[1];
  assign ready = run && (!out_valid || bus.out_ready);

  always_comb begin
    cond = 1'b0;
    case (bus.in_funct3)
      3'b000:  cond = (bus.in_op1 == bus.in_op2);
      3'b001:  cond = (bus.in_op1 != bus.in_op2);
      3'b100:  cond = ($signed(bus.in_op1) <  $signed(bus.in_op2));
      3'b101:  cond = ($signed(bus.in_op1) >= $signed(bus.in_op2));
      3'b110:  cond = (bus.in_op1 <  bus.in_op2);
      3'b111:  cond = (bus.in_op1 >= bus.in_op2);
      default: cond = 1'b0;
    endcase

    illegal = !bus.in_is_jal && !bus.in_is_jalr &&
              ((bus.in_funct3 == 3'b010) || (bus.in_funct3 == 3'b011));
    taken   = bus.in_is_jal || bus.in_is_jalr || (!illegal && cond);

    if (bus.in_is_jalr && !bus.in_is_jal) jump_target = (bus.in_op1 + bus.in_imm) & ~64'd1;
    else                                  jump_target = bus.in_pc + bus.in_imm;

    link          = bus.in_pc + 64'd4;
    result_target = taken ? jump_target : link;
    misalign      = taken && jump_target[1];
    mispredict    = (taken != bus.in_pred_taken) ||
                    (taken && (jump_target != bus.in_pred_target));

    // Stale-epoch and flushed beats are consumed but leave no trace.
    capture     = bus.in_valid && ready && (bus.in_epoch == epoch) && !bus.flush;
    do_redirect = capture && mispredict && !illegal && !misalign;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      epoch          <= 1'b0;
      cnt            <= 32'd0;
      out_valid      <= 1'b0;
      out_taken      <= 1'b0;
      out_illegal    <= 1'b0;
      out_misalign   <= 1'b0;
      out_target     <= 64'd0;
      out_link       <= 64'd0;
      redirect_valid <= 1'b0;
    end else begin
      redirect_valid <= do_redirect;
      if (do_redirect) begin
        epoch <= ~epoch;
        if (cnt != 32'hFFFF_FFFF) cnt <= cnt + 32'd1;
      end

      if (bus.flush)          out_valid <= 1'b0;
      else if (capture)       out_valid <= 1'b1;
      else if (bus.out_ready) out_valid <= 1'b0;

      if (capture) begin
        out_taken    <= taken;
        out_illegal  <= illegal;
        out_misalign <= misalign;
        out_target   <= result_target;
        out_link     <= link;
      end
    end
  end

  assign bus.in_ready       = ready;
  assign bus.out_valid      = out_valid;
  assign bus.out_taken      = out_taken;
  assign bus.out_target     = out_target;
  assign bus.out_link       = out_link;
  assign bus.out_illegal    = out_illegal;
  assign bus.out_misalign   = out_misalign;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = out_target;
  assign bus.mispredict_cnt = cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_unit.sv
`default_nettype none
// tb_branch_unit -- directed and randomized checks of branch_unit against a behavioural model.
// Revision: 1.0
module tb_branch_unit;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  branch_unit_if bus ();

  branch_unit dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  int          m_edges;
  logic        m_valid, m_taken, m_ill, m_mis, m_redir, m_epoch;
  logic [63:0] m_target, m_link;
  logic [31:0] m_cnt;

  function automatic void ref_eval(
    input  logic [63:0] pc, input logic [63:0] op1, input logic [63:0] op2, input logic [63:0] imm,
    input  logic [2:0] f3, input logic jal, input logic jalr, input logic ptk, input logic [63:0] ptg,
    output logic tk, output logic [63:0] tg, output logic [63:0] lk,
    output logic ill, output logic mis, output logic mp);
    longint signed   sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     dest;
    logic            c;
    sa = op1; sb = op2; ua = op1; ub = op2;
    ill = 1'b0;
    c   = 1'b0;
    if (jal) begin
      c = 1'b1; dest = pc + imm;
    end else if (jalr) begin
      c = 1'b1; dest = op1 + imm; dest[0] = 1'b0;
    end else begin
      dest = pc + imm;
      case (f3)
        3'd0: c = (ua == ub);
        3'd1: c = (ua != ub);
        3'd4: c = (sa < sb);
        3'd5: c = (sa >= sb);
        3'd6: c = (ua < ub);
        3'd7: c = (ua >= ub);
        default: ill = 1'b1;
      endcase
    end
    lk  = pc + 64'd4;
    tk  = c;
    tg  = tk ? dest : lk;
    mis = tk && dest[1];
    mp  = (tk != ptk) || (tk && (dest != ptg));
  endfunction

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_op1 = '0; bus.in_op2 = '0; bus.in_imm = '0;
    bus.in_funct3 = '0; bus.in_is_jal = 1'b0; bus.in_is_jalr = 1'b0; bus.in_pred_taken = 1'b0;
    bus.in_pred_target = '0; bus.in_epoch = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
  endtask

  task automatic set_beat(input logic [63:0] pc, input logic [63:0] op1, input logic [63:0] op2,
                          input logic [63:0] imm, input logic [2:0] f3, input logic jal,
                          input logic jalr, input logic ptk, input logic [63:0] ptg, input logic ep);
    bus.in_valid = 1'b1; bus.in_pc = pc; bus.in_op1 = op1; bus.in_op2 = op2; bus.in_imm = imm;
    bus.in_funct3 = f3; bus.in_is_jal = jal; bus.in_is_jalr = jalr; bus.in_pred_taken = ptk;
    bus.in_pred_target = ptg; bus.in_epoch = ep;
  endtask

  task automatic model_clear();
    m_edges = 0; m_valid = 0; m_taken = 0; m_ill = 0; m_mis = 0; m_redir = 0; m_epoch = 0;
    m_target = '0; m_link = '0; m_cnt = '0;
  endtask

  // Advance one clock, updating the model from the inputs presented during that cycle.
  task automatic tick();
    logic tk, ill, mis, mp, rdy, keep, redir;
    logic [63:0] tg, lk;
    ref_eval(bus.in_pc, bus.in_op1, bus.in_op2, bus.in_imm, bus.in_funct3, bus.in_is_jal,
             bus.in_is_jalr, bus.in_pred_taken, bus.in_pred_target, tk, tg, lk, ill, mis, mp);
    rdy   = (m_edges >= 2) && (!m_valid || bus.out_ready);
    keep  = bus.in_valid && rdy && (bus.in_epoch == m_epoch) && !bus.flush;
    redir = keep && mp && !ill && !mis;
    @(posedge clock); #1;
    if (m_edges < 2) m_edges++;
    m_redir = redir;
    if (redir) begin
      m_epoch = ~m_epoch;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
    end
    if (bus.flush)          m_valid = 1'b0;
    else if (keep)          m_valid = 1'b1;
    else if (bus.out_ready) m_valid = 1'b0;
    if (keep) begin
      m_taken = tk; m_target = tg; m_link = lk; m_ill = ill; m_mis = mis;
    end
  endtask

  task automatic apply_reset();
    idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    model_clear();
    reset_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_clear();
    set_beat(64'h100, 0, 0, 64'h20, 3'd0, 1'b1, 1'b0, 1'b1, 64'h120, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if ({bus.out_valid, bus.redirect_valid, bus.mispredict_cnt, bus.out_target, bus.out_link} !== '0)
      $display("FAIL reset_outputs: got valid=%b redir=%b cnt=%h tgt=%h link=%h required all zero",
               bus.out_valid, bus.redirect_valid, bus.mispredict_cnt, bus.out_target, bus.out_link);
    else n_pass++;
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL reset_release_accept: out_valid=%b required 0", bus.out_valid);
    else n_pass++;
    repeat (2) tick();
    n_checks++;
    if (bus.out_valid !== m_valid || m_valid !== 1'b1)
      $display("FAIL reset_first_beat: out_valid=%b required %b", bus.out_valid, m_valid);
    else n_pass++;
    idle();
    tick();
  endtask

  task automatic test_bltu();
    logic [31:0] c0;
    c0 = m_cnt;
    set_beat(64'h8000_0000, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 3'b110, 1'b0, 1'b0, 1'b0, 64'h0, m_epoch);
    tick();
    idle();
    n_checks++;
    if ({bus.out_valid, bus.out_taken, bus.out_target, bus.redirect_valid, bus.redirect_pc} !==
        {1'b1, 1'b1, 64'h8000_0010, 1'b1, 64'h8000_0010})
      $display("FAIL bltu_result: valid=%b taken=%b tgt=%h redir=%b rpc=%h required 1 1 80000010 1 80000010",
               bus.out_valid, bus.out_taken, bus.out_target, bus.redirect_valid, bus.redirect_pc);
    else n_pass++;
    n_checks++;
    if (bus.mispredict_cnt !== c0 + 32'd1)
      $display("FAIL bltu_cnt: got %h required %h", bus.mispredict_cnt, c0 + 32'd1);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.redirect_valid !== 1'b0)
      $display("FAIL bltu_single_pulse: redirect_valid=%b required 0", bus.redirect_valid);
    else n_pass++;
  endtask

  task automatic test_blt();
    logic [31:0] c0;
    c0 = m_cnt;
    set_beat(64'h8000_0000, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 3'b100, 1'b0, 1'b0, 1'b0, 64'h0, m_epoch);
    tick();
    idle();
    n_checks++;
    if ({bus.out_valid, bus.out_taken, bus.out_target, bus.redirect_valid, bus.mispredict_cnt} !==
        {1'b1, 1'b0, 64'h8000_0004, 1'b0, c0})
      $display("FAIL blt_result: valid=%b taken=%b tgt=%h redir=%b cnt=%h required 1 0 80000004 0 %h",
               bus.out_valid, bus.out_taken, bus.out_target, bus.redirect_valid, bus.mispredict_cnt, c0);
    else n_pass++;
    tick();
  endtask

  task automatic test_jalr();
    logic [31:0] c0;
    c0 = m_cnt;
    set_beat(64'h2000, 64'h1003, 64'h0, 64'h0, 3'b000, 1'b0, 1'b1, 1'b1, 64'h1002, m_epoch);
    tick();
    n_checks++;
    if ({bus.out_valid, bus.out_taken, bus.out_target, bus.out_link, bus.redirect_valid} !==
        {1'b1, 1'b1, 64'h1002, 64'h2004, 1'b0})
      $display("FAIL jalr_predicted: valid=%b taken=%b tgt=%h link=%h redir=%b required 1 1 1002 2004 0",
               bus.out_valid, bus.out_taken, bus.out_target, bus.out_link, bus.redirect_valid);
    else n_pass++;
    bus.in_pred_target = 64'h1000;
    tick();
    idle();
    n_checks++;
    if ({bus.out_target, bus.out_misalign, bus.redirect_valid, bus.mispredict_cnt} !==
        {64'h1002, 1'b1, 1'b0, c0})
      $display("FAIL jalr_misalign: tgt=%h mis=%b redir=%b cnt=%h required 1002 1 0 %h",
               bus.out_target, bus.out_misalign, bus.redirect_valid, bus.mispredict_cnt, c0);
    else n_pass++;
    tick();
  endtask

  task automatic test_illegal();
    set_beat(64'h3000, 64'h5, 64'h5, 64'h40, 3'b010, 1'b0, 1'b0, 1'b1, 64'h3040, m_epoch);
    tick();
    idle();
    n_checks++;
    if ({bus.out_valid, bus.out_illegal, bus.out_taken, bus.out_target, bus.redirect_valid} !==
        {1'b1, 1'b1, 1'b0, 64'h3004, 1'b0})
      $display("FAIL illegal_funct3: valid=%b ill=%b taken=%b tgt=%h redir=%b required 1 1 0 3004 0",
               bus.out_valid, bus.out_illegal, bus.out_taken, bus.out_target, bus.redirect_valid);
    else n_pass++;
    tick();
  endtask

  task automatic test_epoch();
    logic        old_ep;
    logic [31:0] c0;
    old_ep = m_epoch;
    set_beat(64'h4000, 0, 0, 64'h100, 3'b000, 1'b1, 1'b0, 1'b0, 64'h0, m_epoch);
    tick();
    c0 = m_cnt;
    set_beat(64'h5000, 0, 0, 64'h100, 3'b000, 1'b1, 1'b0, 1'b0, 64'h0, old_ep);
    tick();
    n_checks++;
    if ({bus.out_valid, bus.redirect_valid, bus.mispredict_cnt} !== {1'b0, 1'b0, c0})
      $display("FAIL epoch_stale_drop: valid=%b redir=%b cnt=%h required 0 0 %h",
               bus.out_valid, bus.redirect_valid, bus.mispredict_cnt, c0);
    else n_pass++;
    set_beat(64'h6000, 0, 0, 64'h100, 3'b000, 1'b1, 1'b0, 1'b1, 64'h6100, ~old_ep);
    tick();
    idle();
    n_checks++;
    if ({bus.out_valid, bus.out_target, bus.redirect_valid} !== {1'b1, 64'h6100, 1'b0})
      $display("FAIL epoch_live_beat: valid=%b tgt=%h redir=%b required 1 6100 0",
               bus.out_valid, bus.out_target, bus.redirect_valid);
    else n_pass++;
    tick();
  endtask

  task automatic test_backpressure();
    int n_redir;
    n_redir = 0;
    set_beat(64'h7000, 0, 0, 64'h200, 3'b000, 1'b1, 1'b0, 1'b0, 64'h0, m_epoch);
    bus.out_ready = 1'b0;
    tick();
    if (bus.redirect_valid === 1'b1) n_redir++;
    set_beat(64'h9000, 0, 0, 64'h300, 3'b000, 1'b1, 1'b0, 1'b0, 64'h0, m_epoch);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.redirect_valid === 1'b1) n_redir++;
      n_checks++;
      if ({bus.out_valid, bus.out_taken, bus.out_target, bus.out_link, bus.in_ready} !==
          {1'b1, 1'b1, 64'h7200, 64'h7004, 1'b0})
        $display("FAIL stall_hold: valid=%b taken=%b tgt=%h link=%h in_ready=%b required 1 1 7200 7004 0",
                 bus.out_valid, bus.out_taken, bus.out_target, bus.out_link, bus.in_ready);
      else n_pass++;
    end
    n_checks++;
    if (n_redir != 1) $display("FAIL stall_redirects: got %0d required 1", n_redir);
    else n_pass++;
    idle();
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL stall_drain: out_valid=%b required 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_flush();
    logic [31:0] c0;
    c0 = m_cnt;
    set_beat(64'hA000, 0, 0, 64'h40, 3'b000, 1'b1, 1'b0, 1'b0, 64'h0, m_epoch);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.redirect_valid, bus.mispredict_cnt} !== {1'b0, 1'b0, c0})
      $display("FAIL flush_drop: valid=%b redir=%b cnt=%h required 0 0 %h",
               bus.out_valid, bus.redirect_valid, bus.mispredict_cnt, c0);
    else n_pass++;
    tick();
    idle();
    n_checks++;
    if ({bus.out_valid, bus.redirect_valid, bus.redirect_pc} !== {1'b1, 1'b1, 64'hA040})
      $display("FAIL flush_epoch_kept: valid=%b redir=%b rpc=%h required 1 1 a040",
               bus.out_valid, bus.redirect_valid, bus.redirect_pc);
    else n_pass++;
    tick();
  endtask

  task automatic test_saturation();
    force dut.cnt = 32'hFFFF_FFFE;
    #1;
    release dut.cnt;
    m_cnt = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      set_beat(64'hB000 + 64'(i * 16), 0, 0, 64'h80, 3'b000, 1'b1, 1'b0, 1'b0, 64'h0, m_epoch);
      tick();
      idle();
      tick();
      n_checks++;
      if (bus.mispredict_cnt !== 32'hFFFF_FFFF)
        $display("FAIL cnt_saturate_%0d: got %h required ffffffff", i, bus.mispredict_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic        tk, ill, mis, mp;
    logic [63:0] tg, lk, a, b;
    logic [11:0] i12;
    for (int n = 0; n < 400; n++) begin
      idle();
      a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: b = a;
        1: begin a = 64'($urandom_range(0, 7)); b = 64'($urandom_range(0, 7)); end
        2: b = {$urandom, $urandom};
        default: b = a ^ 64'h8000_0000_0000_0000;
      endcase
      i12 = 12'($urandom);
      bus.in_valid      = ($urandom_range(0, 3) != 0);
      bus.in_pc         = {$urandom, $urandom} & ~64'h3;
      bus.in_op1        = a;
      bus.in_op2        = b;
      bus.in_imm        = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : {{52{i12[11]}}, i12};
      bus.in_funct3     = 3'($urandom);
      bus.in_is_jal     = ($urandom_range(0, 7) == 0);
      bus.in_is_jalr    = ($urandom_range(0, 7) == 0);
      bus.in_pred_taken = 1'($urandom);
      ref_eval(bus.in_pc, a, b, bus.in_imm, bus.in_funct3, bus.in_is_jal, bus.in_is_jalr,
               1'b0, 64'h0, tk, tg, lk, ill, mis, mp);
      bus.in_pred_target = ($urandom_range(0, 1) == 0) ? tg : {$urandom, $urandom};
      bus.in_epoch       = ($urandom_range(0, 7) == 0) ? ~m_epoch : m_epoch;
      bus.flush          = ($urandom_range(0, 15) == 0);
      bus.out_ready      = ($urandom_range(0, 3) != 0);
      #1;
      n_checks++;
      if (bus.in_ready !== ((m_edges >= 2) && (!m_valid || bus.out_ready)))
        $display("FAIL rand_in_ready[%0d]: got %b required %b", n, bus.in_ready,
                 (m_edges >= 2) && (!m_valid || bus.out_ready));
      else n_pass++;
      tick();
      n_checks++;
      if (bus.out_valid !== m_valid)
        $display("FAIL rand_out_valid[%0d]: got %b required %b", n, bus.out_valid, m_valid);
      else n_pass++;
      if (m_valid) begin
        n_checks++;
        if ({bus.out_taken, bus.out_target, bus.out_link, bus.out_illegal, bus.out_misalign} !==
            {m_taken, m_target, m_link, m_ill, m_mis})
          $display("FAIL rand_result[%0d]: got t=%b tgt=%h link=%h ill=%b mis=%b required t=%b tgt=%h link=%h ill=%b mis=%b",
                   n, bus.out_taken, bus.out_target, bus.out_link, bus.out_illegal, bus.out_misalign,
                   m_taken, m_target, m_link, m_ill, m_mis);
        else n_pass++;
      end
      n_checks++;
      if (bus.redirect_valid !== m_redir || (m_redir && bus.redirect_pc !== m_target))
        $display("FAIL rand_redirect[%0d]: got %b pc=%h required %b pc=%h", n,
                 bus.redirect_valid, bus.redirect_pc, m_redir, m_target);
      else n_pass++;
      n_checks++;
      if (bus.mispredict_cnt !== m_cnt)
        $display("FAIL rand_cnt[%0d]: got %h required %h", n, bus.mispredict_cnt, m_cnt);
      else n_pass++;
    end
    idle();
    tick();
  endtask

  task automatic test_reset_midbeat();
    set_beat(64'hC000, 0, 0, 64'h100, 3'b000, 1'b1, 1'b0, 1'b0, 64'h0, m_epoch);
    tick();
    set_beat(64'hD000, 0, 0, 64'h100, 3'b000, 1'b1, 1'b0, 1'b0, 64'h0, m_epoch);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.out_taken, bus.out_target, bus.out_link, bus.out_illegal,
         bus.out_misalign, bus.redirect_valid, bus.redirect_pc, bus.mispredict_cnt} !== '0)
      $display("FAIL midbeat_reset_zero: valid=%b tgt=%h link=%h redir=%b cnt=%h required all zero",
               bus.out_valid, bus.out_target, bus.out_link, bus.redirect_valid, bus.mispredict_cnt);
    else n_pass++;
    @(posedge clock);
    #1;
    n_checks++;
    if ({bus.out_valid, bus.redirect_valid} !== 2'b00)
      $display("FAIL midbeat_no_redirect: valid=%b redir=%b required 0 0", bus.out_valid, bus.redirect_valid);
    else n_pass++;
    apply_reset();
  endtask

  initial begin
    idle();
    model_clear();
    test_reset();
    test_bltu();
    test_blt();
    test_jalr();
    test_illegal();
    test_epoch();
    test_backpressure();
    test_flush();
    test_saturation();
    apply_reset();
    test_random();
    test_reset_midbeat();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
